// File: rtl/count_sequence_monitor.sv
// Sequence checker for a 3-bit binary/Gray counter: decodes each accepted
// sample, verifies it is the legal successor of the previous one, and reports
// wraps, sequence errors, mode changes and lock status.
module count_sequence_monitor #(
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             M,
  input  logic [2:0]       Count,
  output logic [2:0]       BinValue,
  output logic             Valid,
  output logic             Wrap,
  output logic             SeqErr,
  output logic             ModeChg,
  output logic             Locked,
  output logic [CNT_W-1:0] WrapCount,
  output logic [CNT_W-1:0] ErrCount
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TH = 4'(LOCK_N);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_prev_dec;
  logic       r_prev_m;
  logic [3:0] r_streak, w_streak_nxt, w_streak_inc;
  logic [2:0] w_dec, w_succ;
  logic       w_wrap, w_seq_err, w_mode_chg;

  assign w_dec        = M ? {Count[2], Count[2] ^ Count[1], Count[2] ^ Count[1] ^ Count[0]}
                          : Count;
  assign w_succ       = 3'(r_prev_dec + 3'd1);
  assign w_streak_inc = (r_streak == 4'hF) ? r_streak : 4'(r_streak + 4'd1);

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_wrap       = 1'b0;
    w_seq_err    = 1'b0;
    w_mode_chg   = 1'b0;
    if (En) begin
      if (r_state == ST_INIT) begin
        w_state_nxt  = ST_ACQ;
        w_streak_nxt = 4'd0;
      end else if (M != r_prev_m) begin
        w_mode_chg   = 1'b1;
        w_state_nxt  = ST_ACQ;
        w_streak_nxt = 4'd0;
      end else if (w_dec == r_prev_dec) begin
        w_state_nxt  = r_state;   // upstream stalled: hold everything
      end else if (w_dec == w_succ) begin
        w_streak_nxt = w_streak_inc;
        if (w_streak_inc >= LOCK_TH) w_state_nxt = ST_LOCK;
        w_wrap       = (r_prev_dec == 3'd7);
      end else begin
        w_seq_err    = 1'b1;
        w_state_nxt  = ST_ACQ;
        w_streak_nxt = 4'd0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_INIT;
      r_streak   <= 4'd0;
      r_prev_dec <= 3'd0;
      r_prev_m   <= 1'b0;
      BinValue   <= 3'd0;
      Valid      <= 1'b0;
      Wrap       <= 1'b0;
      SeqErr     <= 1'b0;
      ModeChg    <= 1'b0;
      WrapCount  <= '0;
      ErrCount   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      Valid    <= En;
      Wrap     <= w_wrap;
      SeqErr   <= w_seq_err;
      ModeChg  <= w_mode_chg;
      if (En) begin
        BinValue   <= w_dec;
        r_prev_dec <= w_dec;
        r_prev_m   <= M;
      end
      // Event counters saturate; the pulses above still fire when full.
      if (w_wrap && (WrapCount != '1))   WrapCount <= WrapCount + 1'b1;
      if (w_seq_err && (ErrCount != '1)) ErrCount  <= ErrCount + 1'b1;
    end
  end

  assign Locked = (r_state == ST_LOCK);

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Scoreboard bench for count_sequence_monitor: a behavioural model queues the
// expected outputs for two instances (LOCK_N=4/CNT_W=2 and LOCK_N=1/CNT_W=8).
module tb_count_sequence_monitor;

  typedef struct packed {
    bit [2:0] bin;
    bit       valid, wrap, seqerr, modechg, locked;
    int       wrapc, errc;
  } exp_t;

  typedef struct packed {
    bit       has_ref;
    bit [2:0] pdec;
    bit       pm;
    int       streak;
    bit       locked;
    exp_t     o;
  } mdl_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, En = 1'b0, M = 1'b0;
  logic [2:0] Count = 3'd0;

  logic [2:0] a_bin, b_bin;
  logic       a_valid, a_wrap, a_seqerr, a_modechg, a_locked;
  logic       b_valid, b_wrap, b_seqerr, b_modechg, b_locked;
  logic [1:0] a_wrapc, a_errc;
  logic [7:0] b_wrapc, b_errc;

  int n_vec = 0;
  int n_err = 0;
  mdl_t  ma = '0, mb = '0;
  pair_t sb[$];

  always #5 Clk = ~Clk;

  count_sequence_monitor #(.LOCK_N(4), .CNT_W(2)) dut_a (
    .Clk(Clk), .Reset(Reset), .En(En), .M(M), .Count(Count),
    .BinValue(a_bin), .Valid(a_valid), .Wrap(a_wrap), .SeqErr(a_seqerr),
    .ModeChg(a_modechg), .Locked(a_locked), .WrapCount(a_wrapc), .ErrCount(a_errc)
  );

  count_sequence_monitor #(.LOCK_N(1), .CNT_W(8)) dut_b (
    .Clk(Clk), .Reset(Reset), .En(En), .M(M), .Count(Count),
    .BinValue(b_bin), .Valid(b_valid), .Wrap(b_wrap), .SeqErr(b_seqerr),
    .ModeChg(b_modechg), .Locked(b_locked), .WrapCount(b_wrapc), .ErrCount(b_errc)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit [2:0] decode(input bit m, input bit [2:0] c);
    bit [2:0] b;
    if (!m) return c;
    b[2] = c[2];
    for (int i = 1; i >= 0; i--) b[i] = b[i+1] ^ c[i];
    return b;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input int lock_n, input int cmax,
                                    input bit rst, input bit en, input bit m,
                                    input bit [2:0] cnt);
    mdl_t n;
    bit [2:0] d;
    n = s;
    n.o.valid = 0; n.o.wrap = 0; n.o.seqerr = 0; n.o.modechg = 0;
    if (rst) return '0;
    if (!en) return n;
    d = decode(m, cnt);
    n.o.valid = 1;
    n.o.bin   = d;
    if (!s.has_ref) begin
      n.has_ref = 1; n.streak = 0; n.locked = 0;
    end else if (m != s.pm) begin
      n.o.modechg = 1; n.streak = 0; n.locked = 0;
    end else if (d == s.pdec) begin
      n.streak = s.streak;
    end else if (int'(d) == (int'(s.pdec) + 1) % 8) begin
      n.streak = (s.streak < 15) ? s.streak + 1 : 15;
      if (n.streak >= lock_n) n.locked = 1;
      if (s.pdec == 3'd7) begin
        n.o.wrap = 1;
        if (n.o.wrapc < cmax) n.o.wrapc++;
      end
    end else begin
      n.o.seqerr = 1; n.streak = 0; n.locked = 0;
      if (n.o.errc < cmax) n.o.errc++;
    end
    n.pdec = d;
    n.pm   = m;
    n.o.locked = n.locked;
    return n;
  endfunction

  task automatic compare_out();
    pair_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("a_bin",     32'(a_bin),     32'(e.a.bin));
    check("a_valid",   32'(a_valid),   32'(e.a.valid));
    check("a_wrap",    32'(a_wrap),    32'(e.a.wrap));
    check("a_seqerr",  32'(a_seqerr),  32'(e.a.seqerr));
    check("a_modechg", 32'(a_modechg), 32'(e.a.modechg));
    check("a_locked",  32'(a_locked),  32'(e.a.locked));
    check("a_wrapc",   32'(a_wrapc),   32'(e.a.wrapc));
    check("a_errc",    32'(a_errc),    32'(e.a.errc));
    check("b_bin",     32'(b_bin),     32'(e.b.bin));
    check("b_wrap",    32'(b_wrap),    32'(e.b.wrap));
    check("b_seqerr",  32'(b_seqerr),  32'(e.b.seqerr));
    check("b_locked",  32'(b_locked),  32'(e.b.locked));
    check("b_wrapc",   32'(b_wrapc),   32'(e.b.wrapc));
    check("b_errc",    32'(b_errc),    32'(e.b.errc));
  endtask

  task automatic step(input bit rst, input bit en, input bit m, input bit [2:0] cnt);
    @(negedge Clk);
    Reset = rst; En = en; M = m; Count = cnt;
    ma = mdl_step(ma, 4, 3, rst, en, m, cnt);
    mb = mdl_step(mb, 1, 255, rst, en, m, cnt);
    sb.push_back('{a: ma.o, b: mb.o});
    @(posedge Clk);
    #1;
    compare_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit [2:0] gray_seq [9];
    bit [2:0] v;
    bit       m;
    int       pulses;
    gray_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_bin", 32'(a_bin), 32'd0);
    check("rst_locked", 32'(a_locked), 32'd0);

    // Binary sweep 0..7,0,1
    for (int i = 0; i < 10; i++) step(0, 1, 0, 3'(i % 8));
    check("bsweep_wrapc", 32'(a_wrapc), 32'd1);
    check("bsweep_errc", 32'(a_errc), 32'd0);
    check("bsweep_locked", 32'(a_locked), 32'd1);

    // Gray sweep
    for (int i = 0; i < 9; i++) step(0, 1, 1, gray_seq[i]);
    check("gsweep_bin", 32'(a_bin), 32'd0);
    check("gsweep_locked", 32'(a_locked), 32'd1);

    // Lock in binary, then an illegal step
    for (int i = 2; i <= 6; i++) step(0, 1, 0, 3'(i));
    check("ill_pre_locked", 32'(a_locked), 32'd1);
    step(0, 1, 0, 3'd2);
    check("ill_seqerr", 32'(a_seqerr), 32'd1);
    check("ill_locked", 32'(a_locked), 32'd0);
    step(0, 1, 0, 3'd3);
    step(0, 1, 0, 3'd4);
    check("ill_relock_wait", 32'(a_locked), 32'd0);
    step(0, 1, 0, 3'd5);
    step(0, 1, 0, 3'd6);
    check("ill_relock", 32'(a_locked), 32'd1);

    // Mode switch with a value jump
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3'(i));
    step(0, 1, 1, 3'b101);
    check("msw_modechg", 32'(a_modechg), 32'd1);
    check("msw_seqerr", 32'(a_seqerr), 32'd0);
    check("msw_bin", 32'(a_bin), 32'd6);
    step(0, 1, 1, 3'b100);
    check("msw_next_bin", 32'(a_bin), 32'd7);
    // 7 -> 0 across a mode change is a new reference, not a wrap
    step(0, 1, 0, 3'd0);
    check("msw_wrap", 32'(a_wrap), 32'd0);

    // Idle cycles: pulses low, state held
    for (int i = 0; i < 3; i++) step(0, 0, 1, 3'($urandom_range(0, 7)));
    check("idle_valid", 32'(a_valid), 32'd0);

    // Hold, then reset with En high, then first sample after reset
    for (int i = 0; i < 5; i++) step(0, 1, 0, 3'd0);
    check("hold_seqerr", 32'(a_seqerr), 32'd0);
    step(1, 1, 0, 3'd3);
    check("rst_en_valid", 32'(a_valid), 32'd0);
    check("rst_en_bin", 32'(a_bin), 32'd0);
    step(0, 1, 0, 3'd5);
    check("post_rst_seqerr", 32'(a_seqerr), 32'd0);
    check("post_rst_bin", 32'(a_bin), 32'd5);

    // Saturation of the 2-bit error counter
    step(1, 0, 0, 0);
    step(0, 1, 0, 3'd0);
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 3'((3 * i) % 8));
      if (a_seqerr === 1'b1) pulses++;
    end
    check("sat_pulses", 32'(pulses), 32'd5);
    check("sat_errc", 32'(a_errc), 32'd3);

    // Random mostly-legal traffic
    v = 3'd0;
    m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) m = ~m;
      if ($urandom_range(0, 9) < 8) v = 3'(v + 3'd1);
      else if ($urandom_range(0, 1) == 0) v = 3'($urandom_range(0, 7));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, m,
           m ? (v ^ (v >> 1)) : v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_sequence_monitor.md
# count_sequence_monitor

Downstream checker for the 3-bit binary/Gray mode counter. It samples the counter's `Count` and mode `M` every enabled clock and decodes the value to binary. It verifies that each sample is the legal successor of the previous one, and reports wrap-arounds, sequence errors and a lock indication. It sits directly after the counter and feeds status LEDs and self-check logic.

## Interface
- `LOCK_N`, 4: number of consecutive correct steps required to assert `Locked` (legal range 1..15).
- `CNT_W`, 8: width of the saturating `WrapCount` and `ErrCount` counters.
- `Clk`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset; overrides all other inputs.
- `En`  in  1  sample enable; `Count`/`M` are accepted on a rising edge with `En`=1.
- `M`  in  1  mode of the sampled value: 0 = binary, 1 = Gray.
- `Count`  in  3  counter value to check.
- `BinValue`  out  3  decoded binary value of the last accepted sample.
- `Valid`  out  1  one-cycle pulse per accepted sample.
- `Wrap`  out  1  one-cycle pulse on a correct step 7→0 (decoded).
- `SeqErr`  out  1  one-cycle pulse on an illegal step.
- `ModeChg`  out  1  one-cycle pulse when the accepted `M` differs from the previous accepted `M`.
- `Locked`  out  1  level; a correct-step streak of at least `LOCK_N` has been reached.
- `WrapCount`  out  `CNT_W`  saturating count of `Wrap` events.
- `ErrCount`  out  `CNT_W`  saturating count of `SeqErr` events.

## Operation
- Decode: `dec` = `Count` when `M`=0. When `M`=1, `dec` = gray2bin(`Count`): b2=g2, b1=g2^g1, b0=b1^g0.
- Legal Gray order: 000,001,011,010,110,111,101,100,000.
- Internal registers:
  - `prev_dec[2:0]`, `prev_m`, `streak[3:0]`.
  - FSM with states INIT, ACQ, LOCK.
- INIT: no reference sample is held. On an accepted sample: store `dec`/`M`, `streak`=0, go to ACQ. No check is performed, so no `SeqErr`, `Wrap` or `ModeChg`.
- ACQ and LOCK, per accepted sample, with the first matching rule applied:
  1. `M` != `prev_m`: pulse `ModeChg`. The sample becomes the new reference with no check. `streak`=0; go to ACQ; `Locked`=0.
  2. `dec` == `prev_dec`: hold (upstream stalled or held in reset). No pulse apart from `Valid`; `streak` and state are unchanged.
  3. `dec` == `prev_dec`+1 mod 8: correct step.
     - `streak` increments, saturating at 15.
     - If the new `streak` ≥ `LOCK_N`, go to or stay in LOCK.
     - If `prev_dec`=7, pulse `Wrap` and increment `WrapCount`.
  4. Otherwise: pulse `SeqErr` and increment `ErrCount`. `streak`=0; go to ACQ. The sample becomes the new reference.
- On every accepted sample: `BinValue`←`dec`, `prev_dec`←`dec`, `prev_m`←`M`, and `Valid` pulses.
- `En`=0: all state holds and every pulse output is 0.
- `Locked` = (state == LOCK).
- Saturation: `WrapCount` and `ErrCount` stop at 2^`CNT_W`−1 and never wrap. The pulse still fires when saturated.

## Timing
- Reset (synchronous, checked before `En`) forces:
  - state INIT;
  - `BinValue`=0, `Valid`=0, `Wrap`=0, `SeqErr`=0, `ModeChg`=0, `Locked`=0;
  - `WrapCount`=0, `ErrCount`=0;
  - `prev_dec`=0, `prev_m`=0, `streak`=0.
- Latency: all outputs are registered. The result for a sample presented before edge k is visible immediately after edge k.
- Reset mid-operation discards the reference. The first sample after reset is never flagged, even in the same mode.
- `Reset` and `En` high on the same edge: reset wins and the sample is dropped.
- `LOCK_N`=1: LOCK is entered on the first correct step after the reference.
- A mode change and a value jump on the same sample produce `ModeChg` only, never `SeqErr`.
- A step from 7 to 0 that follows a mode change is a new reference, not a `Wrap`.

## Test plan
- Binary sweep: reset 2 cycles, then `En`=1, `M`=0, `Count`=0..7,0,1.
  - `BinValue` follows 0..7,0,1 one cycle late.
  - `Locked` rises after the 4th correct step.
  - One `Wrap` pulse; `WrapCount`=1; `ErrCount`=0.
- Gray sweep: `M`=1, `Count`=000,001,011,010,110,111,101,100,000.
  - `BinValue`=0..7,0.
  - `Wrap`=1 once; no `SeqErr`; `Locked`=1.
- Illegal step while locked: binary 3,4,5,6 then 2.
  - `SeqErr` pulses once; `ErrCount`=1; `Locked` drops.
  - Next 3 then 4 are legal, no error; `Locked` stays 0 until 4 correct steps.
- Mode switch: binary 0,1,2, then `M`=1 with `Count`=101.
  - `ModeChg`=1, `SeqErr`=0, `BinValue`=6.
  - Next `Count`=100 gives `BinValue`=7 as a correct step.
- Hold and reset: `Count` held at 000 for 5 samples → no `SeqErr`, `streak` unchanged.
  - Then `Reset` pulse with `En`=1 → all outputs 0 next cycle and state INIT.
  - Next sample `Count`=5 is accepted with no error.
- Saturation: with `CNT_W`=2, inject 5 errors.
  - `ErrCount` stops at 3; `SeqErr` pulses all 5 times.
